mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised multi-cycle multiply/divide unit for the pipelined CPU, sitting beside the ALU in the EX stage and owning the HI/LO register pair. It replaces the fixed-width, behaviourally-divided unit with a WIDTH-generic design that has a configurable multiply latency and a true radix-2 restoring divider. It also adds an abort input for exception flush and defined divide-by-zero results. The pipeline stalls on `real_busy`.

## Interface
- `WIDTH`, 32: operand, HI and LO width; must be ≥ 4.
- `MUL_LAT`, 5: cycles from accepted multiply to HI/LO commit; must be ≥ 1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `start` in 1: launch the multiply/divide class op on `op`.
- `cancel` in 1: abort the op in flight (exception flush).
- `op` in 4: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu.
- `d1` in WIDTH: rs operand (dividend / mthi/mtlo source).
- `d2` in WIDTH: rt operand (divisor).
- `busy` out 1: registered; high while an op is in flight.
- `real_busy` out 1: `busy | start`; the stall request.
- `mdu_out` out WIDTH: combinational; HI if op=mfhi, LO if op=mflo, else 0.

## Operation
- States:
  - IDLE
  - MUL: down-counter runs for MUL_LAT cycles.
  - DIV_ITER: WIDTH iterations.
  - DIV_FIX: sign fix, then commit.
- Start is accepted only in IDLE with `cancel`=0. Start while busy, or with op outside {1,2,3,4,9..12}, is ignored.
- On acceptance, operands are latched; later changes to `d1`/`d2` have no effect.
- Multiply: the 2·WIDTH product is signed (mult, madd, msub) or unsigned (multu, maddu, msubu). It is held in a MUL_LAT-deep delay register.
  - At commit, mult/multu write {HI,LO} = product.
  - At commit, madd/maddu write {HI,LO} += product; msub/msubu write {HI,LO} −= product. Arithmetic is modulo 2^(2·WIDTH).
- Divide:
  - The acceptance edge latches |d1| and |d2| (raw values for divu) and records both signs. State goes to DIV_ITER.
  - Each iteration performs one shift-subtract-restore step, giving one quotient bit MSB first.
  - DIV_FIX negates the quotient if the signs differ and gives the remainder the sign of the dividend. It writes LO = quotient and HI = remainder.
- Divisor 0, both div and divu: LO = all-ones, HI = d1. This is not trapped, and the full latency still applies.
- Signed overflow, MIN / −1: LO = MIN, HI = 0.
- mthi/mtlo: at an edge with op=7/8, `start`=0 and `busy`=0, write HI/LO = d1. Ignored while busy.
- mfhi/mflo always return committed HI/LO, never in-flight results.
- `cancel`=1 at an edge: FSM goes to IDLE and `busy` drops. HI/LO are unchanged, and a `start` on the same edge is ignored.
- Reset (any time, including mid-operation): HI, LO, counter and operand registers all go to 0. FSM goes to IDLE, `busy`=0, so `mdu_out`=0 and `real_busy` = `start`.

## Timing
- Let E0 be the edge that accepts `start`.
  - Multiply: `busy`=1 from after E0 until edge E0+MUL_LAT, which commits HI/LO and clears `busy`.
  - Divide: commit and `busy` clear occur at E0+WIDTH+1.
- `real_busy` is high in the start cycle and every busy cycle. The first instruction that can read the new HI/LO issues in the cycle after commit.
- A new start can be accepted in the first cycle after `busy` falls.
- The back-to-back restriction is enforced by the pipeline stall, not by internal queueing. There is no buffering; at most one op is in flight.

## Configuration
- `MDU_ACC_EN` defined: ops 9–12 (madd/maddu/msub/msubu) are implemented as above.
- `MDU_ACC_EN` undefined: ops 9–12 are treated as op 0. Start is ignored, `busy` stays 0, and there is no accumulator adder in hardware.

## Test plan
- mult, d1=0xFFFFFFFE, d2=3, MUL_LAT=5 -> `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, and mfhi/mflo return those.
- div, d1=−7 (0xFFFFFFF9), d2=2 -> commit at E0+33; LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu on the same operands -> LO=0x7FFFFFFC, HI=1.
- divu, d1=0x1234, d2=0 -> LO=0xFFFFFFFF, HI=0x1234. div, d1=0x80000000, d2=0xFFFFFFFF -> LO=0x80000000, HI=0.
- With `MDU_ACC_EN`: mthi 0, mtlo 10, then madd 3×4 -> LO=22. Then msubu 5×5 -> {HI,LO}=0xFFFFFFFF_FFFFFFFD.
- Start div, then assert `cancel` at E0+10 -> `busy`=0 next cycle and HI/LO keep their pre-op values. Repeat with reset pulled low at E0+10 -> HI=LO=0 immediately, with no clock edge needed.
- mtlo 5 while `busy`=1 -> ignored, LO keeps the div result. A second start during busy -> ignored, and a single commit is observed.

Source files
------------

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: handshake and operand bundle between the EX stage and the
// multiply/divide unit. The EX stage is the master, mdu_iter is the slave.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             cancel;
  logic [3:0]       op;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic             busy;
  logic             real_busy;
  logic [WIDTH-1:0] mdu_out;

  modport master (
    output start, cancel, op, d1, d2,
    input  busy, real_busy, mdu_out
  );

  modport slave (
    input  start, cancel, op, d1, d2,
    output busy, real_busy, mdu_out
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit owning the HI/LO pair.
// Multiplies commit MUL_LAT edges after acceptance through a product delay
// line; divides run a radix-2 restoring divider (WIDTH steps plus a sign-fix
// cycle). Optional feature macro: MDU_ACC_EN enables madd/maddu/msub/msubu
// (ops 9..12); without it those ops are ignored and no accumulator exists.
module mdu_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic        clk,
  input  logic        reset,
  mdu_iter_if.slave   bus
);

  localparam int W2    = 2 * WIDTH;
  localparam int CMAX  = (MUL_LAT > WIDTH) ? MUL_LAT : WIDTH;
  localparam int CNT_W = $clog2(CMAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_ACC_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MUL      = 2'd1,
    S_DIV_ITER = 2'd2,
    S_DIV_FIX  = 2'd3
  } state_t;

  // Conditional two's-complement negate, shared by operand abs and sign fix.
  function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] v,
                                              input logic             neg);
    return neg ? -v : v;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [WIDTH-1:0]  r_hi;
  logic [WIDTH-1:0]  r_lo;

  // Divider operand/working registers
  logic [WIDTH-1:0]  r_quo;   // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]  r_rem;
  logic [WIDTH-1:0]  r_dvs;
  logic              r_sn_q;
  logic              r_sn_r;
  logic              r_dz;

  // Product delay line
  logic [W2-1:0]     r_mpipe [MUL_LAT];

  logic              w_busy;
  logic              w_op_mul;
  logic              w_op_div;
  logic              w_mul_sgn;
  logic              w_div_sgn;
  logic              w_accept;
  logic              w_go_mul;
  logic              w_go_div;
  logic              w_mt_ok;
  logic              w_commit_mul;
  logic              w_commit_div;
  logic [W2-1:0]     w_ext_a;
  logic [W2-1:0]     w_ext_b;
  logic [W2-1:0]     w_prod;
  logic [W2-1:0]     w_mul_res;
  logic [WIDTH:0]    w_rem_sh;
  logic [WIDTH:0]    w_rem_diff;
  logic              w_qbit;
  logic [WIDTH-1:0]  w_rem_nxt;
  logic [WIDTH-1:0]  w_quo_fix;
  logic [WIDTH-1:0]  w_rem_fix;

  // ---------------------------------------------------------------- decode
`ifdef MDU_ACC_EN
  assign w_op_mul  = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
                     (bus.op == OP_MADD) || (bus.op == OP_MADDU) ||
                     (bus.op == OP_MSUB) || (bus.op == OP_MSUBU);
  assign w_mul_sgn = (bus.op == OP_MULT) || (bus.op == OP_MADD) ||
                     (bus.op == OP_MSUB);
`else
  assign w_op_mul  = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign w_mul_sgn = (bus.op == OP_MULT);
`endif
  assign w_op_div  = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign w_div_sgn = (bus.op == OP_DIV);

  assign w_busy   = (r_state != S_IDLE);
  assign w_accept = bus.start && !bus.cancel && !w_busy;
  assign w_go_mul = w_accept && w_op_mul;
  assign w_go_div = w_accept && w_op_div;
  assign w_mt_ok  = !bus.start && !bus.cancel && !w_busy;

  assign bus.busy      = w_busy;
  assign bus.real_busy = w_busy | bus.start;

  // ---------------------------------------------------------------- multiply input stage
  assign w_ext_a = {{WIDTH{w_mul_sgn & bus.d1[WIDTH-1]}}, bus.d1};
  assign w_ext_b = {{WIDTH{w_mul_sgn & bus.d2[WIDTH-1]}}, bus.d2};
  assign w_prod  = w_ext_a * w_ext_b;

  // Product delay line: the product captured at acceptance reaches the last
  // stage exactly on the commit edge, leaving room for retiming the multiplier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MUL_LAT; i++) r_mpipe[i] <= '0;
    end else begin
      r_mpipe[0] <= w_prod;
      for (int i = 1; i < MUL_LAT; i++) r_mpipe[i] <= r_mpipe[i-1];
    end
  end

  // ---------------------------------------------------------------- accumulate stage
`ifdef MDU_ACC_EN
  logic r_acc_add;
  logic r_acc_sub;

  // Remember whether the multiply in flight accumulates into HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc_add <= 1'b0;
      r_acc_sub <= 1'b0;
    end else if (w_go_mul) begin
      r_acc_add <= (bus.op == OP_MADD) || (bus.op == OP_MADDU);
      r_acc_sub <= (bus.op == OP_MSUB) || (bus.op == OP_MSUBU);
    end
  end

  // Commit value: plain product, or HI/LO plus/minus product (mod 2^(2W)).
  always_comb begin
    w_mul_res = r_mpipe[MUL_LAT-1];
    if (r_acc_add)      w_mul_res = {r_hi, r_lo} + r_mpipe[MUL_LAT-1];
    else if (r_acc_sub) w_mul_res = {r_hi, r_lo} - r_mpipe[MUL_LAT-1];
  end
`else
  assign w_mul_res = r_mpipe[MUL_LAT-1];
`endif

  // ---------------------------------------------------------------- divide step
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_dvs};
  assign w_qbit     = ~w_rem_diff[WIDTH];
  assign w_rem_nxt  = w_qbit ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

  // ---------------------------------------------------------------- divide sign fix
  assign w_quo_fix = f_cneg(r_quo, r_sn_q);
  assign w_rem_fix = f_cneg(r_rem, r_sn_r);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and commit strobes; cancel overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_commit_mul = 1'b0;
    w_commit_div = 1'b0;
    if (bus.cancel) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_go_mul)      w_state_nxt = S_MUL;
          else if (w_go_div) w_state_nxt = S_DIV_ITER;
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            w_state_nxt  = S_IDLE;
            w_commit_mul = 1'b1;
          end
        end
        S_DIV_ITER: begin
          if (r_cnt == '0) w_state_nxt = S_DIV_FIX;
        end
        S_DIV_FIX: begin
          w_state_nxt  = S_IDLE;
          w_commit_div = 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Latency counter: loaded on acceptance, counts down while an op runs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_go_mul) begin
      r_cnt <= CNT_W'(MUL_LAT - 1);
    end else if (w_go_div) begin
      r_cnt <= CNT_W'(WIDTH - 1);
    end else if (!bus.cancel && (r_state == S_MUL || r_state == S_DIV_ITER) &&
                 r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Divider operands: latch magnitudes and signs, then shift-subtract-restore.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_sn_q <= 1'b0;
      r_sn_r <= 1'b0;
      r_dz   <= 1'b0;
    end else if (w_go_div) begin
      r_quo  <= f_cneg(bus.d1, w_div_sgn & bus.d1[WIDTH-1]);
      r_dvs  <= f_cneg(bus.d2, w_div_sgn & bus.d2[WIDTH-1]);
      r_rem  <= '0;
      r_sn_q <= w_div_sgn & (bus.d1[WIDTH-1] ^ bus.d2[WIDTH-1]);
      r_sn_r <= w_div_sgn & bus.d1[WIDTH-1];
      r_dz   <= (bus.d2 == '0);
    end else if (!bus.cancel && r_state == S_DIV_ITER) begin
      r_quo <= {r_quo[WIDTH-2:0], w_qbit};
      r_rem <= w_rem_nxt;
    end
  end

  // HI/LO: multiply/divide commits and mthi/mtlo moves (only when idle).
  // A zero divisor forces LO to all-ones; the restoring loop already leaves
  // the dividend in HI for that case.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit_mul) begin
      r_hi <= w_mul_res[W2-1:WIDTH];
      r_lo <= w_mul_res[WIDTH-1:0];
    end else if (w_commit_div) begin
      r_hi <= w_rem_fix;
      r_lo <= r_dz ? '1 : w_quo_fix;
    end else if (w_mt_ok && bus.op == OP_MTHI) begin
      r_hi <= bus.d1;
    end else if (w_mt_ok && bus.op == OP_MTLO) begin
      r_lo <= bus.d1;
    end
  end

  // Read port: committed HI/LO only.
  always_comb begin
    bus.mdu_out = '0;
    if (bus.op == OP_MFHI)      bus.mdu_out = r_hi;
    else if (bus.op == OP_MFLO) bus.mdu_out = r_lo;
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: randomized and directed bench for mdu_iter (WIDTH=32,
// MUL_LAT=5) against an arithmetic reference model of HI/LO.
module tb_mdu_iter;

  localparam int W = 32;
  localparam int L = 5;
  localparam int DIV_LAT = W + 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mdu_iter_if #(.WIDTH(W)) bus();

  mdu_iter #(.WIDTH(W), .MUL_LAT(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  // Reference model: apply one op's architectural effect to HI/LO.
  task automatic model_apply(input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b);
    logic [63:0] p;
    logic [63:0] acc;
    int          sa;
    int          sb;
    acc = {m_hi, m_lo};
    p   = '0;
    if (op == 4'd1 || op == 4'd9 || op == 4'd11)
      p = 64'(longint'($signed(a)) * longint'($signed(b)));
    else if (op == 4'd2 || op == 4'd10 || op == 4'd12)
      p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1, 4'd2:   acc = p;
      4'd9, 4'd10:  acc = acc + p;
      4'd11, 4'd12: acc = acc - p;
      4'd3, 4'd4: begin
        if (b == 32'd0) begin
          acc = {a, 32'hFFFF_FFFF};
        end else if (op == 4'd3 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          acc = {32'd0, 32'h8000_0000};
        end else if (op == 4'd3) begin
          sa = a;
          sb = b;
          acc = {32'(sa % sb), 32'(sa / sb)};
        end else begin
          acc = {a % b, a / b};
        end
      end
      4'd7: acc[63:32] = a;
      4'd8: acc[31:0]  = a;
      default: ;
    endcase
    m_hi = acc[63:32];
    m_lo = acc[31:0];
  endtask

  // All stimulus tasks start and end just after a falling edge.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    bus.op = op; bus.d1 = a; bus.d2 = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 4'd0; bus.d1 = $urandom; bus.d2 = $urandom;
    lat = 0;
    while (bus.busy === 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic write_mt(input logic [3:0] op, input logic [31:0] v);
    bus.op = op; bus.d1 = v;
    @(negedge clk);
    bus.op = 4'd0; bus.d1 = $urandom;
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    bus.op = 4'd5; #1 hi = bus.mdu_out;
    bus.op = 4'd6; #1 lo = bus.mdu_out;
    bus.op = 4'd0; #1;
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    logic [31:0] hi, lo;
    reset = 1'b0;
    #2 bus.start = 1'b1; bus.op = 4'd1;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_vec++;
    if (bus.real_busy !== 1'b1) begin n_err++; $display("FAIL reset_real_busy got %b want 1", bus.real_busy); end
    bus.start = 1'b0; bus.op = 4'd0;
    #1;
    n_vec++;
    if (bus.real_busy !== 1'b0) begin n_err++; $display("FAIL reset_real_busy_idle got %b want 0", bus.real_busy); end
    read_hilo(hi, lo);
    n_vec++;
    if (hi !== 32'd0 || lo !== 32'd0) begin n_err++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus.mdu_out !== 32'd0) begin n_err++; $display("FAIL mdu_out_noread got %h want 0", bus.mdu_out); end
  endtask

  task automatic test_mul_directed();
    int lat;
    logic [31:0] hi, lo;
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, lat);
    model_apply(4'd1, 32'hFFFF_FFFE, 32'd3);
    read_hilo(hi, lo);
    n_vec++;
    if (lat != L) begin n_err++; $display("FAIL mult_latency got %0d want %0d", lat, L); end
    n_vec++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      n_err++; $display("FAIL mult_result got %h_%h want ffffffff_fffffffa", hi, lo);
    end
  endtask

  task automatic test_div_directed();
    logic [3:0]  ops [5] = '{4'd3, 4'd4, 4'd4, 4'd3, 4'd3};
    logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h1234, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] ehi [5] = '{32'hFFFF_FFFF, 32'd1, 32'h1234, 32'd0, 32'hFFFF_FFF9};
    logic [31:0] elo [5] = '{32'hFFFF_FFFD, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    int lat;
    logic [31:0] hi, lo;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], lat);
      model_apply(ops[i], as[i], bs[i]);
      read_hilo(hi, lo);
      n_vec++;
      if (lat != DIV_LAT) begin n_err++; $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, DIV_LAT); end
      n_vec++;
      if (hi !== ehi[i] || lo !== elo[i]) begin
        n_err++; $display("FAIL div_result[%0d] got %h/%h want %h/%h", i, hi, lo, ehi[i], elo[i]);
      end
    end
  endtask

  task automatic test_acc();
    int lat;
    logic [31:0] hi, lo;
    write_mt(4'd7, 32'd0); model_apply(4'd7, 32'd0, 32'd0);
    write_mt(4'd8, 32'd10); model_apply(4'd8, 32'd10, 32'd0);
`ifdef MDU_ACC_EN
    run_op(4'd9, 32'd3, 32'd4, lat);
    model_apply(4'd9, 32'd3, 32'd4);
    read_hilo(hi, lo);
    n_vec++;
    if (lat != L || hi !== 32'd0 || lo !== 32'd22) begin
      n_err++; $display("FAIL madd got lat %0d %h/%h want %0d 0/22", lat, hi, lo, L);
    end
    run_op(4'd12, 32'd5, 32'd5, lat);
    model_apply(4'd12, 32'd5, 32'd5);
    read_hilo(hi, lo);
    n_vec++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_err++; $display("FAIL msubu got %h_%h want ffffffff_fffffffd", hi, lo);
    end
    for (int i = 0; i < 8; i++) begin
      logic [3:0] op; logic [31:0] a, b;
      op = 4'(9 + $urandom_range(0, 3)); a = rnd_operand(); b = rnd_operand();
      run_op(op, a, b, lat);
      model_apply(op, a, b);
      read_hilo(hi, lo);
      n_vec++;
      if (lat != L || hi !== m_hi || lo !== m_lo) begin
        n_err++; $display("FAIL acc_rand op %0d got lat %0d %h/%h want %0d %h/%h", op, lat, hi, lo, L, m_hi, m_lo);
      end
    end
`else
    for (int k = 9; k <= 12; k++) begin
      run_op(4'(k), 32'd3, 32'd4, lat);
      read_hilo(hi, lo);
      n_vec++;
      if (lat != 0 || hi !== m_hi || lo !== m_lo) begin
        n_err++; $display("FAIL acc_disabled op %0d got lat %0d %h/%h want 0 %h/%h", k, lat, hi, lo, m_hi, m_lo);
      end
    end
`endif
  endtask

  task automatic test_random();
    int lat;
    int want_lat;
    logic [3:0] op;
    logic [31:0] a, b, hi, lo;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(1, 6));
      a = rnd_operand(); b = rnd_operand();
      if (op >= 4'd5) begin
        op = op + 4'd2;
        write_mt(op, a);
        model_apply(op, a, b);
        want_lat = 0; lat = 0;
      end else begin
        run_op(op, a, b, lat);
        model_apply(op, a, b);
        want_lat = (op <= 4'd2) ? L : DIV_LAT;
      end
      read_hilo(hi, lo);
      n_vec++;
      if (lat != want_lat || hi !== m_hi || lo !== m_lo) begin
        n_err++; $display("FAIL random[%0d] op %0d a %h b %h got lat %0d %h/%h want %0d %h/%h",
                          i, op, a, b, lat, hi, lo, want_lat, m_hi, m_lo);
      end
    end
  endtask

  task automatic test_ignored_ops();
    int lat;
    logic [31:0] hi, lo;
    run_op(4'd5, 32'h1111, 32'h2222, lat);
    n_vec++;
    if (lat != 0) begin n_err++; $display("FAIL start_mfhi_busy got %0d want 0", lat); end
    run_op(4'd7, 32'hDEAD_BEEF, 32'd0, lat);
    run_op(4'd0, 32'hDEAD_BEEF, 32'd0, lat);
    read_hilo(hi, lo);
    n_vec++;
    if (lat != 0 || hi !== m_hi || lo !== m_lo) begin
      n_err++; $display("FAIL start_mthi_ignored got lat %0d %h/%h want 0 %h/%h", lat, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    int seen;
    logic [31:0] a, b, hi, lo;
    a = $urandom; b = $urandom_range(1, 1000);
    bus.op = 4'd3; bus.d1 = a; bus.d2 = b; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 4'd8; bus.d1 = 32'd5;
    @(negedge clk);
    bus.op = 4'd1; bus.d1 = $urandom; bus.d2 = $urandom; bus.start = 1'b1;
    #1;
    n_vec++;
    if (bus.real_busy !== 1'b1) begin n_err++; $display("FAIL real_busy_busy got %b want 1", bus.real_busy); end
    n = 1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 4'd0;
    n = 2;
    while (bus.busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    model_apply(4'd3, a, b);
    read_hilo(hi, lo);
    n_vec++;
    if (n != DIV_LAT) begin n_err++; $display("FAIL busy_ignore_latency got %0d want %0d", n, DIV_LAT); end
    n_vec++;
    if (hi !== m_hi || lo !== m_lo) begin
      n_err++; $display("FAIL busy_ignore_result got %h/%h want %h/%h", hi, lo, m_hi, m_lo);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) seen++;
    end
    read_hilo(hi, lo);
    n_vec++;
    if (seen != 0 || hi !== m_hi || lo !== m_lo) begin
      n_err++; $display("FAIL single_commit got busy %0d cycles %h/%h want 0 %h/%h", seen, hi, lo, m_hi, m_lo);
    end
    @(negedge clk);
  endtask

  task automatic test_cancel();
    logic [31:0] hi, lo, vh, vl;
    vh = $urandom; vl = $urandom;
    write_mt(4'd7, vh); model_apply(4'd7, vh, 32'd0);
    write_mt(4'd8, vl); model_apply(4'd8, vl, 32'd0);
    bus.op = 4'd3; bus.d1 = $urandom; bus.d2 = 32'd7; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 4'd0;
    repeat (9) @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL cancel_pre_busy got %b want 1", bus.busy); end
    bus.cancel = 1'b1; bus.start = 1'b1; bus.op = 4'd1;
    @(negedge clk);
    bus.cancel = 1'b0; bus.start = 1'b0; bus.op = 4'd0;
    n_vec++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL cancel_busy got %b want 0", bus.busy); end
    @(negedge clk);
    read_hilo(hi, lo);
    n_vec++;
    if (bus.busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
      n_err++; $display("FAIL cancel_hilo got busy %b %h/%h want 0 %h/%h", bus.busy, hi, lo, m_hi, m_lo);
    end
    @(negedge clk);
    bus.op = 4'd3; bus.d1 = $urandom; bus.d2 = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 4'd0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0) begin n_err++; $display("FAIL async_reset_busy got %b want 0", bus.busy); end
    read_hilo(hi, lo);
    n_vec++;
    if (hi !== 32'd0 || lo !== 32'd0) begin n_err++; $display("FAIL async_reset_hilo got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    int want_lat;
    logic [3:0] op;
    logic [31:0] a, b, hi, lo;
    for (int i = 0; i < 8; i++) begin
      op = (i % 2 == 0) ? 4'($urandom_range(1, 2)) : 4'($urandom_range(3, 4));
      a = rnd_operand(); b = rnd_operand();
      run_op(op, a, b, lat);
      model_apply(op, a, b);
      want_lat = (op <= 4'd2) ? L : DIV_LAT;
      bus.op = 4'd5; #1 hi = bus.mdu_out;
      bus.op = 4'd6; #1 lo = bus.mdu_out;
      bus.op = 4'd0;
      n_vec++;
      if (lat != want_lat || hi !== m_hi || lo !== m_lo) begin
        n_err++; $display("FAIL b2b[%0d] op %0d got lat %0d %h/%h want %0d %h/%h",
                          i, op, lat, hi, lo, want_lat, m_hi, m_lo);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 4'd0;
    bus.d1 = '0; bus.d2 = '0;
    reset = 1'b0;
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_acc();
    test_random();
    test_ignored_ops();
    test_busy_ignore();
    test_cancel();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
